window_color_probe: RTL and testbench

//  Reads back the video inside the square cursor window and reports its mean colour once per frame.
//  It sits on the same raster as the cursor overlay, fed by the same row/col counters, pixel stream and cursor geometry.
//  It accumulates per-channel sums over the window during a frame.
//  At the next frame start it runs a sequential divide to produce an averaged 24-bit pixel for the colour-pick logic.

---
 rtl/window_color_probe.sv | 192 +++++++++++++++++++
 tb/tb_window_color_probe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_color_probe.sv
// window_color_probe: per-frame mean colour of the square cursor window.
// Build option WIN_PROBE_BORDER_EXCL_EN samples only the window interior.
module window_color_probe #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] row,
    input  logic [12:0] col,
    input  logic [12:0] win_v,
    input  logic [12:0] win_h,
    input  logic [12:0] win_size,
    input  logic [23:0] pixel_in,
    output logic [23:0] avg_out,
    output logic        avg_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int IT_W = $clog2(ACC_W);

    typedef enum logic [2:0] {
        IDLE,
        DIV_R,
        DIV_G,
        DIV_B,
        DONE
    } state_t;

    state_t state, state_n;

    logic [12:0] geo_v, geo_h, geo_s;
    logic [ACC_W-1:0] sum_r, sum_g, sum_b;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] op_g, op_b, quo;
    logic [CNT_W-1:0] div_d;
    logic [CNT_W:0] rem;
    logic [IT_W-1:0] it;
    logic [7:0] res_r, res_g;

    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [7:0] b
    );
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W-7){1'b0}}, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    logic frame_start;
    assign frame_start = (row == 13'd0) && (col == 13'd0);

    // The frame-start pixel is judged against the geometry being latched now.
    logic [13:0] r14, c14, v14, h14, s14;
    assign r14 = {1'b0, row};
    assign c14 = {1'b0, col};
    assign v14 = {1'b0, frame_start ? win_v : geo_v};
    assign h14 = {1'b0, frame_start ? win_h : geo_h};
    assign s14 = {1'b0, frame_start ? win_size : geo_s};

    logic in_row, in_col, in_win;

`ifdef WIN_PROBE_BORDER_EXCL_EN
    assign in_row = (r14 >= v14 + 14'd1) && (r14 + 14'd2 <= v14 + s14);
    assign in_col = (c14 >= h14 + 14'd1) && (c14 + 14'd2 <= h14 + s14);
`else
    assign in_row = (s14 != 14'd0) && (r14 >= v14) && (r14 < v14 + s14);
    assign in_col = (s14 != 14'd0) && (c14 >= h14) && (c14 < h14 + s14);
`endif

    assign in_win = in_row && in_col;

    logic [ACC_W-1:0] base_r, base_g, base_b;
    logic [ACC_W-1:0] next_r, next_g, next_b;
    logic [CNT_W-1:0] base_c, next_c;

    assign base_r = frame_start ? '0 : sum_r;
    assign base_g = frame_start ? '0 : sum_g;
    assign base_b = frame_start ? '0 : sum_b;
    assign base_c = frame_start ? '0 : cnt;

    assign next_r = in_win ? sat_add(base_r, pixel_in[23:16]) : base_r;
    assign next_g = in_win ? sat_add(base_g, pixel_in[15:8]) : base_g;
    assign next_b = in_win ? sat_add(base_b, pixel_in[7:0]) : base_b;
    assign next_c = (in_win && base_c != '1) ? base_c + 1'b1 : base_c;

    logic handoff;
    assign handoff = frame_start && (state == IDLE) && (cnt != '0);

    // One restoring shift-subtract step per cycle.
    logic [CNT_W:0] shifted, rem_n;
    logic [ACC_W-1:0] quo_n;
    logic ge, last_it, dividing;
    logic [7:0] q8;

    assign shifted = {rem[CNT_W-1:0], quo[ACC_W-1]};
    assign ge = shifted >= {1'b0, div_d};
    assign rem_n = ge ? shifted - {1'b0, div_d} : shifted;
    assign quo_n = {quo[ACC_W-2:0], ge};
    assign last_it = (it == IT_W'(ACC_W - 1));
    assign q8 = (|quo_n[ACC_W-1:8]) ? 8'hFF : quo_n[7:0];
    assign dividing = (state == DIV_R) || (state == DIV_G) || (state == DIV_B);

    always_comb begin
        state_n = state;
        busy = 1'b1;
        avg_valid = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (handoff)
                    state_n = DIV_R;
            end
            DIV_R: if (last_it) state_n = DIV_G;
            DIV_G: if (last_it) state_n = DIV_B;
            DIV_B: if (last_it) state_n = DONE;
            DONE: begin
                avg_valid = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            geo_v   <= '0;
            geo_h   <= '0;
            geo_s   <= '0;
            sum_r   <= '0;
            sum_g   <= '0;
            sum_b   <= '0;
            cnt     <= '0;
            op_g    <= '0;
            op_b    <= '0;
            quo     <= '0;
            div_d   <= '0;
            rem     <= '0;
            it      <= '0;
            res_r   <= '0;
            res_g   <= '0;
            avg_out <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            sum_r   <= next_r;
            sum_g   <= next_g;
            sum_b   <= next_b;
            cnt     <= next_c;
            overrun <= frame_start && (state != IDLE);

            if (frame_start) begin
                geo_v <= win_v;
                geo_h <= win_h;
                geo_s <= win_size;
            end

            if (handoff) begin
                quo   <= sum_r;
                op_g  <= sum_g;
                op_b  <= sum_b;
                div_d <= cnt;
                rem   <= '0;
                it    <= '0;
            end else if (dividing) begin
                rem <= rem_n;
                quo <= quo_n;
                it  <= last_it ? '0 : it + 1'b1;
                if (last_it) begin
                    case (state)
                        DIV_R: begin
                            res_r <= q8;
                            quo   <= op_g;
                            rem   <= '0;
                        end
                        DIV_G: begin
                            res_g <= q8;
                            quo   <= op_b;
                            rem   <= '0;
                        end
                        DIV_B: avg_out <= {res_r, res_g, q8};
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_window_color_probe.sv
// tb_window_color_probe: directed vectors and frame-level sequences
// for the window colour probe.
module tb_window_color_probe;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] row, col, win_v, win_h, win_size;
    logic [23:0] pixel_in;
    logic [23:0] avg_out;
    logic        avg_valid, busy, overrun;

    int total = 0;
    int bad = 0;
    logic [23:0] last_avg = 24'h0;

    window_color_probe dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .col(col),
        .win_v(win_v),
        .win_h(win_h),
        .win_size(win_size),
        .pixel_in(pixel_in),
        .avg_out(avg_out),
        .avg_valid(avg_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] v;
        logic [12:0] h;
        logic [12:0] s;
        int          mode;
        logic [23:0] pc;
        bit          valid;
        logic [23:0] avg;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_geo(input logic [12:0] v, input logic [12:0] h,
                           input logic [12:0] s);
        win_v = v;
        win_h = h;
        win_size = s;
    endtask

    // Raster sweep around the window; never touches row 0 / col 0.
    task automatic scan(input int v, input int h, input int s,
                        input int mode, input logic [23:0] pc);
        for (int r = v - 2; r <= v + s + 1; r++) begin
            for (int c = h - 2; c <= h + s + 1; c++) begin
                row = 13'(r);
                col = 13'(c);
                case (mode)
                    1: pixel_in = {8'(r), 8'(c), 8'h55};
                    2: pixel_in = {8'(2 * r + c), 16'h0};
                    default: pixel_in = pc;
                endcase
                tick();
            end
        end
    endtask

    // Frame start at F, then watch F+1..F+80. A forced frame start
    // can be placed at F+force_k, preceded by in-window pixels at (5,5).
    task automatic monitor(input int force_k, input bit exp_valid,
                           input logic [23:0] exp_avg, input int exp_ovr_k);
        int bfirst, blast, bcnt, vcnt, vk, ocnt, ok;
        logic [23:0] vavg;
        bfirst = 0; blast = 0; bcnt = 0; vcnt = 0;
        vk = 0; ocnt = 0; ok = 0; vavg = '0;
        row = 13'd0;
        col = 13'd0;
        pixel_in = 24'h123456;
        tick();
        for (int k = 1; k <= 80; k++) begin
            if (busy) begin
                if (bfirst == 0) bfirst = k;
                blast = k;
                bcnt++;
            end
            if (avg_valid) begin
                vcnt++;
                vk = k;
                vavg = avg_out;
            end
            if (overrun) begin
                ocnt++;
                ok = k;
            end
            if (force_k != 0 && k < force_k) begin
                row = 13'd5;
                col = 13'd5;
            end else if (k == force_k) begin
                row = 13'd0;
                col = 13'd0;
            end else begin
                row = 13'd1;
                col = 13'd1;
            end
            tick();
        end
        if (exp_valid) begin
            check("busy_first", bfirst, 1);
            check("busy_last", blast, 73);
            check("busy_cycles", bcnt, 73);
            check("valid_pulses", vcnt, 1);
            check("valid_cycle", vk, 73);
            check("avg_value", {8'h0, vavg}, {8'h0, exp_avg});
            last_avg = exp_avg;
        end else begin
            check("idle_busy_cycles", bcnt, 0);
            check("idle_valid_pulses", vcnt, 0);
        end
        check("avg_hold", {8'h0, avg_out}, {8'h0, last_avg});
        if (exp_ovr_k != 0) begin
            check("overrun_pulses", ocnt, 1);
            check("overrun_cycle", ok, exp_ovr_k);
        end else begin
            check("overrun_none", ocnt, 0);
        end
    endtask

    task automatic reset_mid_divide();
        int bcnt, vcnt;
        bcnt = 0;
        vcnt = 0;
        row = 13'd0;
        col = 13'd0;
        tick();
        for (int k = 1; k <= 80; k++) begin
            if (busy) bcnt++;
            if (avg_valid) vcnt++;
            if (k == 31) begin
                check("rst_busy", busy, 0);
                check("rst_avg", {8'h0, avg_out}, 32'h0);
                check("rst_overrun", overrun, 0);
            end
            rst = (k == 30) ? 1'b0 : 1'b1;
            row = 13'd1;
            col = 13'd1;
            tick();
        end
        check("rst_busy_cycles", bcnt, 30);
        check("rst_valid_pulses", vcnt, 0);
        check("rst_avg_after", {8'h0, avg_out}, 32'h0);
        last_avg = 24'h0;
    endtask

    initial begin
        vecs[0] = '{13'd46, 13'd165, 13'd60, 0, 24'h4080C0, 1'b1, 24'h4080C0};
`ifdef WIN_PROBE_BORDER_EXCL_EN
        vecs[1] = '{13'd3, 13'd4, 13'd2, 2, 24'h0, 1'b0, 24'h0};
`else
        vecs[1] = '{13'd3, 13'd4, 13'd2, 2, 24'h0, 1'b1, 24'h0B0000};
`endif
        vecs[2] = '{13'd10, 13'd20, 13'd8, 1, 24'h0, 1'b1, 24'h0D1755};
        vecs[3] = '{13'd5, 13'd7, 13'd0, 0, 24'hFFFFFF, 1'b0, 24'h0};
`ifdef WIN_PROBE_BORDER_EXCL_EN
        vecs[4] = '{13'd9, 13'd30, 13'd1, 1, 24'h0, 1'b0, 24'h0};
`else
        vecs[4] = '{13'd9, 13'd30, 13'd1, 1, 24'h0, 1'b1, 24'h091E55};
`endif
        vecs[5] = '{13'd4, 13'd4, 13'd3, 1, 24'h0, 1'b1, 24'h050555};
        vecs[6] = '{13'd20, 13'd40, 13'd5, 2, 24'h0, 1'b1, 24'h560000};

        rst = 1'b0;
        row = 13'd1;
        col = 13'd1;
        pixel_in = 24'h0;
        set_geo(13'd0, 13'd0, 13'd0);
        tick();
        tick();
        check("reset_avg", {8'h0, avg_out}, 32'h0);
        check("reset_valid", avg_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            set_geo(vecs[i].v, vecs[i].h, vecs[i].s);
            if (i == 0)
                monitor(0, 1'b0, 24'h0, 0);
            else
                monitor(0, vecs[i-1].valid, vecs[i-1].avg, 0);
            scan(vecs[i].v, vecs[i].h, vecs[i].s, vecs[i].mode, vecs[i].pc);
        end

        // Mid-frame size change only takes effect at the next frame.
        set_geo(13'd10, 13'd20, 13'd8);
        monitor(0, vecs[6].valid, vecs[6].avg, 0);
        win_size = 13'd16;
        scan(10, 20, 16, 1, 24'h0);
        monitor(0, 1'b1, 24'h0D1755, 0);
        scan(10, 20, 16, 1, 24'h0);

        // Frame start while busy: overrun, first result kept.
        set_geo(13'd4, 13'd4, 13'd3);
        monitor(0, 1'b1, 24'h111B55, 0);
        scan(4, 4, 3, 1, 24'h0);
        monitor(10, 1'b1, 24'h050555, 11);
        monitor(0, 1'b0, 24'h0, 0);
        scan(4, 4, 3, 1, 24'h0);

        // Reset mid-divide, then one empty frame, then a good one.
        reset_mid_divide();
        scan(4, 4, 3, 1, 24'h0);
        monitor(0, 1'b0, 24'h0, 0);
        scan(4, 4, 3, 1, 24'h0);
        monitor(0, 1'b1, 24'h050555, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
